uart_tx_fifo: RTL
=================

# uart_tx_fifo

Synchronous FIFO buffering bytes between a host producer and `uart_tx`. It accepts words on a valid/ready input, stores up to DEPTH entries, and presents them first-word-fall-through on a valid/ready output wired directly to `uart_tx` `i_vld`/`o_rdy`. This lets the host burst data while the transmitter drains at baud rate.

## Interface
- `DATA_WIDTH`, 8: word width; must match `uart_tx`.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AFULL_LEVEL`, 12: `o_afull` asserts when level ≥ this value; range 1..DEPTH.
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_flush`  in  1  synchronous flush; empties the FIFO.
- `i_vld`  in  1  upstream word valid.
- `i_data`  in  DATA_WIDTH  upstream word.
- `o_rdy`  out  1  FIFO can accept a word (`!full && !i_flush`).
- `o_vld`  out  1  head word valid; connect to `uart_tx.i_vld`.
- `o_data`  out  DATA_WIDTH  head word; connect to `uart_tx.i_data`.
- `i_rdy`  in  1  downstream accepts; connect to `uart_tx.o_rdy`.
- `o_level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `o_afull`  out  1  `o_level >= AFULL_LEVEL`.
- `o_empty`  out  1  `o_level == 0`.

## Operation
- Push: `i_vld && o_rdy` at a clk edge writes `i_data` to `mem[wr_ptr]` and increments `wr_ptr`.
- Pop: `o_vld && i_rdy` at a clk edge increments `rd_ptr`.
- Pointers are `$clog2(DEPTH)+1` bits wide. The MSB is a wrap bit, and the low bits index `mem`. Both wrap naturally at 2·DEPTH.
- Full: low bits equal and wrap bits differ. Empty: pointers identical.
- `o_level = wr_ptr - rd_ptr`, computed modulo 2^($clog2(DEPTH)+1).
- `o_vld = !empty`. `o_data = mem[rd_ptr]` (FWFT). While `o_vld=0`, `o_data` is don't-care.
- Simultaneous push and pop: both pointers advance and level is unchanged. This is legal at any non-empty, non-full level.
- When full, `o_rdy=0`, so there is no push and no bypass. A pop in that cycle frees a slot, but `o_rdy` only rises on the following cycle.
- When empty, no pop is possible. A push makes the word visible on the next cycle; there is no combinational in→out path.
- `i_flush=1` sets `rd_ptr <= wr_ptr` and forces `o_rdy=0` in that cycle. Any push or pop in that cycle is ignored. Level reads 0 on the next cycle.
- Upstream holding `i_vld` while `o_rdy=0` is a stall, not an error. `i_data` must remain stable until accepted.
- `uart_tx` handshake: `uart_tx` latches on `i_vld && o_rdy` and drops `o_rdy` while shifting. The FIFO holds `o_vld` high and does not advance until that handshake occurs.

## Timing
- Reset (asynchronous assert, synchronous release): pointers 0, so `o_vld=0`, `o_empty=1`, `o_level=0`, `o_afull=0`, `o_rdy=1`. `mem` contents are not reset.
- Reset asserted mid-operation drops all stored words immediately. No partial state survives.
- Write-to-read latency: 1 cycle (push at edge N, `o_vld`/`o_data` valid after edge N).
- Status outputs (`o_level`, `o_afull`, `o_empty`, `o_rdy`, `o_vld`) all derive from registered pointers and update one edge after the causing handshake.
- `o_rdy` depends only on state and `i_flush`, never on `i_vld`. `o_vld` depends on no input.
- Throughput: one push and one pop per cycle sustained.

## Structure
- `uart_pkg` holds the shared `DATA_WIDTH` default and the parity-mode string constants already used by `uart_tx`/`uart_rx`. `uart_tx_fifo` imports it only for the width default.
- The storage array is one sub-module, `sync_fifo_mem`, a DEPTH×DATA_WIDTH register file. It has a write port (we, waddr, wdata) clocked on clk and an asynchronous read port (raddr → rdata).
- Pointer, flag and flush logic stays in `uart_tx_fifo`. There is no explicit FSM; state is the two pointers.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with `i_rdy=0`: `o_level=3`, `o_vld=1`, `o_data=0x41`. Release `i_rdy`: words pop in order 0x41, 0x42, 0x43, then `o_empty=1`.
- Push 16 words 0x00..0x0F with `i_rdy=0`: `o_afull` rises when `o_level` reaches 12, and `o_rdy=0` at level 16. A 17th push (0xFF) held on `i_vld` is not accepted. Pop one: `o_rdy` returns next cycle, 0xFF is accepted, and the sequence read is 0x00..0x0F, 0xFF.
- Hold level 8, then assert `i_vld` and `i_rdy` together for 40 cycles with incrementing data: level stays 8 throughout, with no loss or duplication across pointer wrap.
- At level 5, assert `i_flush` while `i_vld=1` (data 0x55): next cycle `o_level=0` and `o_vld=0`, and 0x55 is not stored.
- Assert `rst_n=0` mid-stream at level 7, asynchronously between edges: outputs go to reset values immediately, and after release the FIFO accepts and returns 0x7E correctly.
- Connect to `uart_tx` (DATA_WIDTH=7, 100 MHz, 1 Mbaud) and loop back through `uart_rx`: 64 random words are pushed in bursts and received identically and in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width and parity-mode names
// used across uart_tx, uart_rx and the transmit FIFO.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam string PARITY_NONE = "NONE";
  localparam string PARITY_EVEN = "EVEN";
  localparam string PARITY_ODD  = "ODD";

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register file with one clocked write port and one
// asynchronous read port, used as FIFO storage. Contents are not reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write the incoming word into the addressed slot.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO between a host producer and uart_tx.
// State is just the two pointers; each carries an extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_vld,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_rdy,
  output logic                       o_vld,
  output logic [DATA_WIDTH-1:0]      o_data,
  input  logic                       i_rdy,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_afull,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Flush blocks acceptance in the same cycle so no word slips in.
  assign o_rdy   = !w_full && !i_flush;
  assign o_vld   = !w_empty;
  assign w_push  = i_vld && o_rdy;
  assign w_pop   = o_vld && i_rdy;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_afull = (o_level >= PW'(AFULL_LEVEL));
  assign o_empty = w_empty;

  // Advance pointers on handshakes; flush discards everything stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (o_data)
  );

endmodule
